// File: rtl/acq_capture_ctrl.sv
// Capture controller feeding the three capture BRAMs read back by UART_TX_control.
// Collects a frame of N samples, requests transmission, then holds off writes until
// the transmitter reports completion. Optionally re-arms for continuous operation.
module acq_capture_ctrl #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned MAX_N  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              continuous,
  input  logic [15:0]       n_target,
  input  logic              sample_valid,
  input  logic [15:0]       sample_d0,
  input  logic [31:0]       sample_d1,
  input  logic [31:0]       sample_d2,
  input  logic              ReadyTx,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [15:0]       dina0,
  output logic [31:0]       dina1,
  output logic [31:0]       dina2,
  output logic              startTx_main,
  output logic [15:0]       Ndata,
  output logic              busy,
  output logic [15:0]       drop_cnt,
  output logic              cfg_err
);

  // One extra bit over 16 so a frame of exactly MAX_N = 16384 (or 65536) compares cleanly.
  localparam int unsigned     CntW    = 17;
  localparam logic [CntW-1:0] MaxNCnt = CntW'(MAX_N);

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StReqTx,
    StWaitTx
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [CntW-1:0]     n_lat_q, n_lat_d;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [15:0]         dina0_q, dina0_d;
  logic [31:0]         dina1_q, dina1_d;
  logic [31:0]         dina2_q, dina2_d;
  logic                start_q, start_d;
  logic [15:0]         ndata_q, ndata_d;
  logic [15:0]         drop_q, drop_d;
  logic                cfg_err_q, cfg_err_d;

  logic [CntW-1:0]     n_req;
  logic [CntW-1:0]     n_clamped;
  logic [CntW-1:0]     cnt_inc;

  // Requested frame length clamped to what the BRAMs can hold.
  always_comb begin
    n_req     = {1'b0, n_target};
    n_clamped = (n_req > MaxNCnt) ? MaxNCnt : n_req;
    cnt_inc   = cnt_q + CntW'(1);
  end

  // Next-state and registered-output logic for the capture FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_lat_d   = n_lat_q;
    wea_d     = 1'b0;
    addra_d   = addra_q;
    dina0_d   = dina0_q;
    dina1_d   = dina1_q;
    dina2_d   = dina2_q;
    start_d   = 1'b0;
    ndata_d   = ndata_q;
    drop_d    = drop_q;
    cfg_err_d = 1'b0;

    // Samples arriving outside CAPTURE are never written, only counted.
    if (sample_valid && (state_q != StCapture) && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (arm) begin
          if (n_target == 16'd0) begin
            cfg_err_d = 1'b1;
          end else begin
            n_lat_d = n_clamped;
            cnt_d   = '0;
            state_d = StCapture;
          end
        end
      end

      StCapture: begin
        if (sample_valid) begin
          wea_d   = 1'b1;
          addra_d = cnt_q[ADDR_W-1:0];
          dina0_d = sample_d0;
          dina1_d = sample_d1;
          dina2_d = sample_d2;
          cnt_d   = cnt_inc;
          if (cnt_inc == n_lat_q) begin
            state_d = StReqTx;
          end
        end
      end

      // The last write is visible this cycle; the request follows one cycle later.
      StReqTx: begin
        start_d = 1'b1;
        ndata_d = n_lat_q[15:0];
        state_d = StWaitTx;
      end

      StWaitTx: begin
        if (ReadyTx) begin
          if (continuous) begin
            if (n_target == 16'd0) begin
              cfg_err_d = 1'b1;
              state_d   = StIdle;
            end else begin
              n_lat_d = n_clamped;
              cnt_d   = '0;
              state_d = StCapture;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      n_lat_q   <= '0;
      wea_q     <= 1'b0;
      addra_q   <= '0;
      dina0_q   <= '0;
      dina1_q   <= '0;
      dina2_q   <= '0;
      start_q   <= 1'b0;
      ndata_q   <= '0;
      drop_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_lat_q   <= n_lat_d;
      wea_q     <= wea_d;
      addra_q   <= addra_d;
      dina0_q   <= dina0_d;
      dina1_q   <= dina1_d;
      dina2_q   <= dina2_d;
      start_q   <= start_d;
      ndata_q   <= ndata_d;
      drop_q    <= drop_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign wea          = wea_q;
  assign addra        = addra_q;
  assign dina0        = dina0_q;
  assign dina1        = dina1_q;
  assign dina2        = dina2_q;
  assign startTx_main = start_q;
  assign Ndata        = ndata_q;
  assign busy         = (state_q != StIdle);
  assign drop_cnt     = drop_q;
  assign cfg_err      = cfg_err_q;

  // Memory must stay quiet while the transmitter reads it back.
  a_no_write_in_wait : assert property (@(posedge clk) disable iff (reset)
    (state_q == StWaitTx) |-> !wea_q);

  a_start_single : assert property (@(posedge clk) disable iff (reset)
    start_q |=> !start_q);

endmodule

// File: tb/tb_acq_capture_ctrl.sv
// Self-checking bench for acq_capture_ctrl: directed vector table, multi-cycle
// corner sequences and randomized frames against a frame-level reference model.
module tb_acq_capture_ctrl;

  logic        clk;
  logic        reset;
  logic        arm;
  logic        continuous;
  logic [15:0] n_target;
  logic        sample_valid;
  logic [15:0] sample_d0;
  logic [31:0] sample_d1;
  logic [31:0] sample_d2;
  logic        ReadyTx;
  logic        wea;
  logic [13:0] addra;
  logic [15:0] dina0;
  logic [31:0] dina1;
  logic [31:0] dina2;
  logic        startTx_main;
  logic [15:0] Ndata;
  logic        busy;
  logic [15:0] drop_cnt;
  logic        cfg_err;

  acq_capture_ctrl #(
    .ADDR_W(14)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .continuous   (continuous),
    .n_target     (n_target),
    .sample_valid (sample_valid),
    .sample_d0    (sample_d0),
    .sample_d1    (sample_d1),
    .sample_d2    (sample_d2),
    .ReadyTx      (ReadyTx),
    .wea          (wea),
    .addra        (addra),
    .dina0        (dina0),
    .dina1        (dina1),
    .dina2        (dina2),
    .startTx_main (startTx_main),
    .Ndata        (Ndata),
    .busy         (busy),
    .drop_cnt     (drop_cnt),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
  } wr_t;

  typedef struct {
    logic        rst, arm, cont, valid, rdy;
    logic [15:0] n, d0;
    logic        e_wea;
    logic [13:0] e_addr;
    logic        e_start;
    logic [15:0] e_ndata;
    logic        e_busy;
    logic [15:0] e_drop;
    logic        e_cfg;
  } vec_t;

  int  errors = 0;
  int  checks = 0;
  int  start_cnt = 0;
  logic [15:0] last_ndata = '0;
  wr_t obs[$];
  wr_t exp_q[$];
  vec_t vt[14];

  function automatic vec_t mk(input int rst, input int a, input int c, input int v, input int r,
                              input int n, input int d0, input int ew, input int ea,
                              input int es, input int en, input int eb, input int ed,
                              input int ec);
    vec_t x;
    x.rst = 1'(rst);  x.arm = 1'(a);  x.cont = 1'(c);  x.valid = 1'(v);  x.rdy = 1'(r);
    x.n = 16'(n);  x.d0 = 16'(d0);
    x.e_wea = 1'(ew);  x.e_addr = 14'(ea);  x.e_start = 1'(es);  x.e_ndata = 16'(en);
    x.e_busy = 1'(eb);  x.e_drop = 16'(ed);  x.e_cfg = 1'(ec);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Advance one clock and sample outputs 1 ns after the edge; log writes and requests.
  task automatic step();
    @(posedge clk);
    #1;
    if (wea) obs.push_back({2'b00, addra, dina0, dina1, dina2});
    if (startTx_main) begin
      start_cnt++;
      last_ndata = Ndata;
    end
  endtask

  task automatic idle_inputs();
    arm = 1'b0;  continuous = 1'b0;  sample_valid = 1'b0;  ReadyTx = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    obs.delete();
  endtask

  task automatic rand_sample();
    sample_valid = 1'($urandom_range(0, 1));
    sample_d0    = 16'($urandom);
    sample_d1    = $urandom;
    sample_d2    = $urandom;
  endtask

  // Watchdog: every loop is bench-bounded, this only catches a stuck simulator.
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bad;
    int s0;
    idle_inputs();
    reset = 1'b0;  n_target = '0;  sample_d0 = '0;  sample_d1 = '0;  sample_d2 = '0;

    // ---------------- Directed vector table ----------------
    //            rst arm cnt vld rdy  n  d0 | wea adr st nd bsy drp cfg
    vt[0]  = mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 0, 0, 0, 4, 0,   0, 0, 0, 0, 1, 0, 0);
    vt[2]  = mk(0, 0, 0, 1, 0, 4, 1,   1, 0, 0, 0, 1, 0, 0);
    vt[3]  = mk(0, 0, 0, 1, 0, 7, 2,   1, 1, 0, 0, 1, 0, 0);   // n_target change ignored
    vt[4]  = mk(0, 0, 0, 1, 0, 7, 3,   1, 2, 0, 0, 1, 0, 0);
    vt[5]  = mk(0, 0, 0, 1, 0, 7, 4,   1, 3, 0, 0, 1, 0, 0);
    vt[6]  = mk(0, 0, 0, 0, 0, 4, 0,   0, 3, 1, 4, 1, 0, 0);
    vt[7]  = mk(0, 0, 0, 1, 0, 4, 9,   0, 3, 0, 4, 1, 1, 0);
    vt[8]  = mk(0, 0, 0, 1, 0, 4, 9,   0, 3, 0, 4, 1, 2, 0);
    vt[9]  = mk(0, 0, 0, 1, 0, 4, 9,   0, 3, 0, 4, 1, 3, 0);
    vt[10] = mk(0, 0, 0, 0, 1, 4, 0,   0, 3, 0, 4, 0, 3, 0);
    vt[11] = mk(0, 1, 0, 0, 0, 0, 0,   0, 3, 0, 4, 0, 3, 1);
    vt[12] = mk(0, 0, 0, 0, 0, 0, 0,   0, 3, 0, 4, 0, 3, 0);
    vt[13] = mk(0, 0, 0, 0, 1, 4, 0,   0, 3, 0, 4, 0, 3, 0);   // ReadyTx in IDLE ignored

    for (int i = 0; i < 14; i++) begin
      reset = vt[i].rst;  arm = vt[i].arm;  continuous = vt[i].cont;
      sample_valid = vt[i].valid;  ReadyTx = vt[i].rdy;  n_target = vt[i].n;
      sample_d0 = vt[i].d0;
      sample_d1 = {16'hA5A5, vt[i].d0};
      sample_d2 = {vt[i].d0, 16'h5A5A};
      step();
      chk($sformatf("vec%0d_wea", i), 32'(wea), 32'(vt[i].e_wea));
      chk($sformatf("vec%0d_addra", i), 32'(addra), 32'(vt[i].e_addr));
      chk($sformatf("vec%0d_start", i), 32'(startTx_main), 32'(vt[i].e_start));
      chk($sformatf("vec%0d_ndata", i), 32'(Ndata), 32'(vt[i].e_ndata));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'(vt[i].e_drop));
      chk($sformatf("vec%0d_cfg", i), 32'(cfg_err), 32'(vt[i].e_cfg));
      if (vt[i].e_wea) begin
        chk($sformatf("vec%0d_dina0", i), 32'(dina0), 32'(vt[i].d0));
        chk($sformatf("vec%0d_dina1", i), dina1, {16'hA5A5, vt[i].d0});
        chk($sformatf("vec%0d_dina2", i), dina2, {vt[i].d0, 16'h5A5A});
      end
    end
    reset = 1'b0;

    // ---------------- Clamp to MAX_N with sample_valid held high ----------------
    do_reset();
    s0 = start_cnt;
    arm = 1'b1;  n_target = 16'd20000;
    step();
    arm = 1'b0;
    sample_valid = 1'b1;
    for (int i = 0; i < 16384 + 3; i++) begin
      sample_d0 = 16'(i);  sample_d1 = 32'(i * 3);  sample_d2 = ~32'(i);
      step();
    end
    sample_valid = 1'b0;
    ReadyTx = 1'b1;
    step();
    ReadyTx = 1'b0;
    chk("max_writes", 32'(obs.size()), 32'd16384);
    bad = 0;
    foreach (obs[i]) if (obs[i].addr != 16'(i) || obs[i].d0 != 16'(i)) bad++;
    chk("max_addr_seq_bad", 32'(bad), 32'd0);
    chk("max_starts", 32'(start_cnt - s0), 32'd1);
    chk("max_ndata", 32'(last_ndata), 32'd16384);
    chk("max_drop", 32'(drop_cnt), 32'd3);
    chk("max_busy_after", 32'(busy), 32'd0);

    // ---------------- Continuous re-arm, then reset mid-frame ----------------
    do_reset();
    s0 = start_cnt;
    continuous = 1'b1;
    arm = 1'b1;  n_target = 16'd2;
    step();
    arm = 1'b0;
    for (int fr = 0; fr < 2; fr++) begin
      for (int k = 0; k < 2; k++) begin
        sample_valid = 1'b1;
        sample_d0 = 16'(16'h10 * (fr + 1) + k);
        sample_d1 = 32'(fr);  sample_d2 = 32'(k);
        step();
      end
      sample_valid = 1'b0;
      step();
      step();
      ReadyTx = 1'b1;
      step();
      ReadyTx = 1'b0;
      chk($sformatf("cont_busy_rearm%0d", fr), 32'(busy), 32'd1);
    end
    chk("cont_starts", 32'(start_cnt - s0), 32'd2);
    chk("cont_writes", 32'(obs.size()), 32'd4);
    bad = 0;
    foreach (obs[i]) begin
      if (obs[i].addr != 16'(i % 2)) bad++;
      if (obs[i].d0 != 16'(16'h10 * (i / 2 + 1) + i % 2)) bad++;
    end
    chk("cont_addr_data_bad", 32'(bad), 32'd0);
    sample_valid = 1'b1;  sample_d0 = 16'h77;
    step();
    sample_valid = 1'b0;
    chk("cont_f3_wea", 32'(wea), 32'd1);
    s0 = start_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;  continuous = 1'b0;
    chk("rst_wea", 32'(wea), 32'd0);
    chk("rst_addra", 32'(addra), 32'd0);
    chk("rst_dina0", 32'(dina0), 32'd0);
    chk("rst_dina1", dina1, 32'd0);
    chk("rst_dina2", dina2, 32'd0);
    chk("rst_start", 32'(startTx_main), 32'd0);
    chk("rst_ndata", 32'(Ndata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_cfg", 32'(cfg_err), 32'd0);
    repeat (4) step();
    chk("rst_no_start", 32'(start_cnt - s0), 32'd0);

    // ---------------- Sparse samples, one every 7 cycles ----------------
    do_reset();
    s0 = start_cnt;
    arm = 1'b1;  n_target = 16'd3;
    step();
    arm = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (6) begin
        step();
        if (wea) bad++;
      end
      sample_valid = 1'b1;  sample_d0 = 16'(16'hC0 + k);
      step();
      sample_valid = 1'b0;
      chk($sformatf("sparse_wea%0d", k), 32'(wea), 32'd1);
      chk($sformatf("sparse_addr%0d", k), 32'(addra), 32'(k));
      chk($sformatf("sparse_d0_%0d", k), 32'(dina0), 32'(16'hC0 + k));
      chk($sformatf("sparse_nostart%0d", k), 32'(start_cnt - s0), 32'd0);
    end
    chk("sparse_gap_writes", 32'(bad), 32'd0);
    step();
    chk("sparse_start", 32'(startTx_main), 32'd1);
    chk("sparse_ndata", 32'(Ndata), 32'd3);
    ReadyTx = 1'b1;
    step();
    ReadyTx = 1'b0;

    // ---------------- Randomized frames vs frame-level model ----------------
    begin
      int exp_drop;
      do_reset();
      exp_drop = 0;
      for (int f = 0; f < 40; f++) begin
        int n;
        int acc;
        obs.delete();
        exp_q.delete();
        s0 = start_cnt;
        n = (f % 8 == 7) ? 0 : int'($urandom_range(1, 12));
        // Idle cycles: every sample is a drop.
        repeat ($urandom_range(0, 3)) begin
          rand_sample();
          if (sample_valid) exp_drop++;
          step();
        end
        rand_sample();
        if (sample_valid) exp_drop++;
        arm = 1'b1;  n_target = 16'(n);
        step();
        arm = 1'b0;
        sample_valid = 1'b0;
        if (n == 0) begin
          chk($sformatf("rnd%0d_cfg_err", f), 32'(cfg_err), 32'd1);
          chk($sformatf("rnd%0d_busy_cfg", f), 32'(busy), 32'd0);
          continue;
        end
        // First n valid samples after arming form the frame; arm/n_target noise is ignored.
        acc = 0;
        for (int c = 0; c < 2000 && acc < n; c++) begin
          rand_sample();
          arm = 1'($urandom_range(0, 1));
          n_target = 16'($urandom);
          if (sample_valid) begin
            exp_q.push_back({16'(acc), sample_d0, sample_d1, sample_d2});
            acc++;
          end
          step();
        end
        repeat (1 + $urandom_range(0, 3)) begin
          rand_sample();
          if (sample_valid) exp_drop++;
          step();
        end
        rand_sample();
        if (sample_valid) exp_drop++;
        arm = 1'b0;
        ReadyTx = 1'b1;
        step();
        ReadyTx = 1'b0;
        sample_valid = 1'b0;
        chk($sformatf("rnd%0d_writes", f), 32'(obs.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
          if (obs[i] !== exp_q[i]) begin
            bad++;
            if (bad == 1) $display("FAIL rnd%0d_write%0d: got %h, expected %h",
                                   f, i, obs[i], exp_q[i]);
          end
        end
        if (bad != 0) errors++;
        checks++;
        chk($sformatf("rnd%0d_starts", f), 32'(start_cnt - s0), 32'd1);
        chk($sformatf("rnd%0d_ndata", f), 32'(Ndata), 32'(n));
        chk($sformatf("rnd%0d_drop", f), 32'(drop_cnt), 32'(exp_drop));
        chk($sformatf("rnd%0d_busy", f), 32'(busy), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
